// File: rtl/apb_pkg.sv
// Shared constants for the APB master arbiter: FSM state encodings and the
// watchdog counter width helper.
package apb_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SETUP  = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;

  // Watchdog counter must hold TIMEOUT-1; keep one bit when the watchdog is off.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 with wrap and
// returns a one-hot grant plus its index.
module rr_arbiter import apb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant) + k) % NREQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port among NREQ requesters with round-robin
// arbitration, latched commands and a pready watchdog.
//
//   state  | meaning
//   IDLE   | offer req_ready to the round-robin winner, latch its command
//   SETUP  | psel=1, penable=0, clear watchdog counter
//   ACCESS | psel=1, penable=1, wait for pready or watchdog expiry
module apb_master_arbiter import apb_pkg::*; #(
  parameter int DATA    = 32,
  parameter int ADDR    = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*ADDR-1:0] req_addr,
  input  logic [NREQ*DATA-1:0] req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DATA-1:0]      rsp_rdata,
  output logic                 rsp_err,
  output logic [ADDR-1:0]      paddr,
  output logic                 pwrite,
  output logic [DATA-1:0]      pwdata,
  output logic                 psel,
  output logic                 penable,
  input  logic                 pready,
  input  logic [DATA-1:0]      prdata,
  input  logic                 pslverr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = cnt_width(TIMEOUT);

  logic [1:0]      state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_grant;
  logic [ADDR-1:0] cmd_addr;
  logic [DATA-1:0] cmd_wdata;
  logic            cmd_write;
  logic [CW-1:0]   cnt;
  logic            busy;
  logic            timed_out;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (win_grant),
    .idx        (win_idx)
  );

  assign req_ready = (state == IDLE) ? win_grant : '0;

  // APB outputs decode only from registered state so they cannot glitch mid-transfer.
  assign busy    = (state == SETUP) || (state == ACCESS);
  assign psel    = busy;
  assign penable = (state == ACCESS);
  assign paddr   = busy ? cmd_addr  : '0;
  assign pwdata  = busy ? cmd_wdata : '0;
  assign pwrite  = busy & cmd_write;

  assign timed_out = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      last_grant <= IW'(NREQ - 1);
      owner      <= '0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_write  <= 1'b0;
      cnt        <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            cmd_addr  <= req_addr[int'(win_idx)*ADDR +: ADDR];
            cmd_wdata <= req_wdata[int'(win_idx)*DATA +: DATA];
            cmd_write <= req_write[win_idx];
            owner     <= win_idx;
            state     <= SETUP;
          end
        end
        SETUP: begin
          cnt   <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid  <= NREQ'(1) << owner;
            rsp_rdata  <= cmd_write ? '0 : prdata;
            rsp_err    <= pslverr;
            last_grant <= owner;
            state      <= IDLE;
          end else if (timed_out) begin
            rsp_valid  <= NREQ'(1) << owner;
            rsp_err    <= 1'b1;
            last_grant <= owner;
            state      <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: write, waited read, slave error,
// watchdog expiry and rescue, reset mid-ACCESS and round-robin order.
module tb_apb_master_arbiter;

  localparam int DATA = 32;
  localparam int ADDR = 32;
  localparam int NREQ = 4;
  localparam int TIMEOUT = 16;

  logic                 pclk = 1'b0;
  logic                 presetn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*ADDR-1:0] req_addr;
  logic [NREQ*DATA-1:0] req_wdata;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [DATA-1:0]      rsp_rdata;
  logic                 rsp_err;
  logic [ADDR-1:0]      paddr;
  logic                 pwrite;
  logic [DATA-1:0]      pwdata;
  logic                 psel;
  logic                 penable;
  logic                 pready;
  logic [DATA-1:0]      prdata;
  logic                 pslverr;

  int checks = 0;
  int errors = 0;
  int n;
  logic [NREQ-1:0] exp_g;

  apb_master_arbiter #(.DATA(DATA), .ADDR(ADDR), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    presetn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    pready = 1'b1; prdata = '0; pslverr = 1'b0;
    #23;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge pclk);
    presetn = 1'b1;
    step();

    // single write from req0, zero wait
    req_valid = 4'b0001; req_write = 4'b0001;
    req_addr[0*ADDR +: ADDR] = 32'h10; req_wdata[0*DATA +: DATA] = 32'hDEADBEEF;
    #1;
    chk("wr_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    chk("wr_setup_psel", psel, 1);
    chk("wr_setup_penable", penable, 0);
    chk("wr_setup_paddr", paddr, 32'h10);
    chk("wr_setup_pwrite", pwrite, 1);
    chk("wr_setup_pwdata", pwdata, 32'hDEADBEEF);
    chk("wr_setup_ready", req_ready, 0);
    step();
    chk("wr_access_psel", psel, 1);
    chk("wr_access_penable", penable, 1);
    chk("wr_access_paddr", paddr, 32'h10);
    step();
    chk("wr_rsp_valid", rsp_valid, 4'b0001);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_idle_psel", psel, 0);
    chk("wr_idle_paddr", paddr, 0);
    step();
    chk("wr_rsp_pulse", rsp_valid, 0);

    // read from req2 with three wait states
    req_valid = 4'b0100; req_write = 4'b0000;
    req_addr[2*ADDR +: ADDR] = 32'h24;
    pready = 1'b0;
    #1;
    chk("rd_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    req_addr[2*ADDR +: ADDR] = 32'hFFFF;
    chk("rd_setup_pwrite", pwrite, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("rd_access_penable", penable, 1);
      chk("rd_access_paddr", paddr, 32'h24);
      if (i == 3) begin pready = 1'b1; prdata = 32'h12345678; end
      step();
    end
    chk("rd_rsp_valid", rsp_valid, 4'b0100);
    chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("rd_rsp_err", rsp_err, 0);
    prdata = '0;

    // slave error on req1 write, then req2 must beat req1
    req_valid = 4'b0010; req_write = 4'b0010;
    req_addr[1*ADDR +: ADDR] = 32'h44; req_wdata[1*DATA +: DATA] = 32'h55;
    #1;
    chk("err_ready", req_ready, 4'b0010);
    step();
    req_valid = '0;
    pslverr = 1'b1;
    step();
    step();
    pslverr = 1'b0;
    chk("err_rsp_valid", rsp_valid, 4'b0010);
    chk("err_rsp_err", rsp_err, 1);
    req_valid = 4'b0110;
    #1;
    chk("err_next_winner", req_ready, 4'b0100);
    req_valid = '0;

    // watchdog expiry on req3 read
    req_valid = 4'b1000; req_write = 4'b0000;
    req_addr[3*ADDR +: ADDR] = 32'h80;
    pready = 1'b0; prdata = 32'hAAAA5555;
    #1;
    chk("to_ready", req_ready, 4'b1000);
    step();
    req_valid = '0;
    step();
    n = 0;
    while (penable && n < 40) begin n++; step(); end
    chk("to_access_cycles", n, 16);
    chk("to_rsp_valid", rsp_valid, 4'b1000);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_idle_psel", psel, 0);

    // pready on the 16th ACCESS cycle is a normal completion (req0 next)
    req_valid = 4'b0001; req_write = 4'b0000;
    req_addr[0*ADDR +: ADDR] = 32'h30; prdata = 32'hCAFE0001;
    #1;
    chk("to2_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    step();
    n = 0;
    while (penable && n < 40) begin
      n++;
      if (n == 16) pready = 1'b1;
      step();
    end
    chk("to2_access_cycles", n, 16);
    chk("to2_rsp_valid", rsp_valid, 4'b0001);
    chk("to2_rsp_err", rsp_err, 0);
    chk("to2_rsp_rdata", rsp_rdata, 32'hCAFE0001);

    // reset in the middle of ACCESS
    pready = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("mid_ready", req_ready, 4'b0010);
    step();
    req_valid = '0;
    step();
    chk("mid_access_penable", penable, 1);
    #2;
    presetn = 1'b0;
    #1;
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_err", rsp_err, 0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 0);
    @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    pready = 1'b1;
    step();
    chk("mid_no_rsp", rsp_valid, 0);

    // round-robin with all four requesting, from reset
    req_valid = 4'b1111;
    #1;
    for (int t = 0; t < 8; t++) begin
      exp_g = 4'b0001 << (t % 4);
      chk("rr_grant", req_ready, exp_g);
      step();
      step();
      step();
      chk("rr_rsp_valid", rsp_valid, exp_g);
    end
    req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "time limit");
  end

endmodule
